// File: rtl/camera_pkg.sv
// Shared types and constants for the camera frame FIFO.
// Entries are packed as {last, keep, data}.
package camera_pkg;

   localparam int ENTRY_W = 73;

   typedef enum logic [1:0] {
      PASS = 2'd0,
      DROP = 2'd1,
      TERM = 2'd2
   } fifo_state_t;

   // Closes a frame whose own last word was lost to overflow.
   localparam logic [ENTRY_W-1:0] TERM_WORD = {1'b1, 8'hFF, 64'h0};

endpackage

// File: rtl/camera_fifo_ram.sv
// Simple dual-port RAM, DEPTH x ENTRY_W, one write port and a registered read port.
// The read register doubles as the stream output register of the FIFO.
module camera_fifo_ram
   import camera_pkg::*;
#(
   parameter int DEPTH = 512,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [AW-1:0]      rd_addr,
   output logic [ENTRY_W-1:0] rd_data
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] rd_data_q;
   logic [ENTRY_W-1:0] rd_data_d;

   // NOTE: the storage array is deliberately not reset; only the read register is, so the array maps onto block RAM.
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/camera_frame_fifo.sv
// Frame-aware elastic buffer from the pixel packer to the S2MM stream port.
// On overflow the rest of the frame is dropped and the frame is still closed with a tlast.
module camera_frame_fifo
   import camera_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int CNT_W = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   frame_rst,
   input  logic [63:0]            in_data,
   input  logic [7:0]             in_keep,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic [63:0]            m_tdata,
   output logic [7:0]             m_tkeep,
   output logic                   m_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   overflow,
   output logic [CNT_W-1:0]       drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   fifo_state_t        state_q, state_d, eff_state;
   logic [LW-1:0]      count_q, count_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               m_tvalid_q, m_tvalid_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   drop_count_q, drop_count_d;

   logic               full;
   logic               drop;
   logic               wr_en;
   logic [ENTRY_W-1:0] wr_data;
   logic               rd_en;
   logic               pop;
   logic               ram_has;
   logic [ENTRY_W-1:0] rd_data;

   // Write side: accept, drop, or close the frame with the terminator.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      full      = (count_q == FULL_LVL);
      eff_state = (frame_rst && state_q == DROP) ? TERM : state_q;
      state_d   = eff_state;
      wr_en     = 1'b0;
      wr_data   = {in_last, in_keep, in_data};
      drop      = 1'b0;
      unique case (eff_state)
         PASS: begin
            if (in_valid) begin
               if (!full) begin
                  wr_en = 1'b1;
               end else begin
                  drop    = 1'b1;
                  state_d = in_last ? TERM : DROP;
               end
            end
         end
         DROP: begin
            if (in_valid) begin
               if (!in_last) begin
                  drop = 1'b1;
               end else if (!full) begin
                  wr_en   = 1'b1;
                  state_d = PASS;
               end else begin
                  drop    = 1'b1;
                  state_d = TERM;
               end
            end
         end
         TERM: begin
            drop = in_valid;
            if (!full) begin
               wr_en   = 1'b1;
               wr_data = TERM_WORD;
               state_d = PASS;
            end
         end
         default: state_d = PASS;
      endcase
   end

   // Frame statistics: a coincident frame_rst clears before the word is counted.
   always_comb begin
      overflow_d   = frame_rst ? 1'b0 : overflow_q;
      drop_count_d = frame_rst ? '0 : drop_count_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_d != '1) begin
            drop_count_d = drop_count_d + CNT_W'(1);
         end
      end
   end

   // Read side: count includes the output register, so RAM holds data when count exceeds m_tvalid.
   always_comb begin
      pop        = m_tvalid_q & m_tready;
      ram_has    = (count_q > LW'(m_tvalid_q));
      rd_en      = ram_has & (~m_tvalid_q | m_tready);
      m_tvalid_d = m_tvalid_q;
      if (rd_en) begin
         m_tvalid_d = 1'b1;
      end else if (pop) begin
         m_tvalid_d = 1'b0;
      end
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q + LW'(wr_en) - LW'(pop);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= PASS;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         m_tvalid_q   <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         m_tvalid_q   <= m_tvalid_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   camera_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign {m_tlast, m_tkeep, m_tdata} = rd_data;
   assign m_tvalid   = m_tvalid_q;
   assign fill_level = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_camera_frame_fifo.sv
// Directed bench for camera_frame_fifo with a 16-deep FIFO and an 8-bit drop counter.
// A per-cycle vector table covers latency and handshaking; sequences cover overflow corners.
module tb_camera_frame_fifo;
   import camera_pkg::*;

   localparam int DEPTH = 16;
   localparam int CNT_W = 8;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        frame_rst = 1'b0;
   logic [63:0] in_data = '0;
   logic [7:0]  in_keep = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic [4:0]  fill_level;
   logic        overflow;
   logic [7:0]  drop_count;

   int total = 0;
   int bad = 0;
   int stable_bad = 0;

   logic [72:0] outq[$];
   logic [72:0] expq[$];
   logic [72:0] cur;
   logic [72:0] prev_word = '0;
   logic        prev_stall = 1'b0;

   camera_frame_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .sys_clk    (clk),
      .sys_rst    (sys_rst),
      .frame_rst  (frame_rst),
      .in_data    (in_data),
      .in_keep    (in_keep),
      .in_last    (in_last),
      .in_valid   (in_valid),
      .m_tdata    (m_tdata),
      .m_tkeep    (m_tkeep),
      .m_tlast    (m_tlast),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .fill_level (fill_level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   assign cur = {m_tlast, m_tkeep, m_tdata};

   // Inputs change just after posedge, so the negedge sees what the next edge will act on.
   always @(negedge clk) begin
      if (sys_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_tvalid || cur != prev_word)) stable_bad++;
         if (m_tvalid && m_tready) outq.push_back(cur);
         prev_stall = m_tvalid && !m_tready;
         prev_word  = cur;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        frame_rst;
      logic        in_valid;
      logic        in_last;
      logic        m_tready;
      logic [63:0] in_data;
      logic [7:0]  in_keep;
      logic        exp_valid;
      logic        exp_last;
      logic [63:0] exp_data;
      logic [7:0]  exp_keep;
      logic [4:0]  exp_fill;
      logic        exp_ov;
      logic [7:0]  exp_dc;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(logic fr, logic iv, logic il, logic rdy, logic [63:0] d,
                               logic [7:0] k, logic ev, logic el, logic [63:0] ed,
                               logic [7:0] ek, logic [4:0] ef, logic eo, logic [7:0] edc);
      vec_t v;
      v.frame_rst = fr;  v.in_valid = iv;  v.in_last = il;  v.m_tready = rdy;
      v.in_data   = d;   v.in_keep  = k;   v.exp_valid = ev; v.exp_last = el;
      v.exp_data  = ed;  v.exp_keep = ek;  v.exp_fill = ef;  v.exp_ov = eo;
      v.exp_dc    = edc;
      return v;
   endfunction

   function automatic logic [72:0] w(logic last, logic [7:0] keep, logic [63:0] d);
      return {last, keep, d};
   endfunction

   task automatic check(string name, logic [72:0] act, logic [72:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      frame_rst = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic push_word(logic fr, logic [63:0] d, logic last);
      frame_rst = fr;
      in_valid  = 1'b1;
      in_data   = d;
      in_keep   = 8'hFF;
      in_last   = last;
      tick();
      idle();
   endtask

   task automatic drain_and_compare(string name, int budget);
      int n = 0;
      m_tready = 1'b1;
      while (outq.size() < expq.size() && n < budget) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check({name, " count"}, 73'(outq.size()), 73'(expq.size()));
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         check($sformatf("%s word %0d", name, i), outq[i], expq[i]);
      end
      outq.delete();
      expq.delete();
   endtask

   initial begin
      // Reset state
      idle();
      repeat (2) tick();
      check("rst m_tvalid", 73'(m_tvalid), 73'(0));
      check("rst m_tlast", 73'(m_tlast), 73'(0));
      check("rst m_tdata", 73'(m_tdata), 73'(0));
      check("rst m_tkeep", 73'(m_tkeep), 73'(0));
      check("rst fill", 73'(fill_level), 73'(0));
      check("rst overflow", 73'(overflow), 73'(0));
      check("rst drop_count", 73'(drop_count), 73'(0));
      sys_rst = 1'b0;

      // Per-cycle vectors: expected outputs are those seen after the edge ending that cycle.
      vecs[0] = mk(1, 1, 0, 0, 64'hA1, 8'h0F, 0, 0, 64'h0,  8'h00, 5'd1, 0, 8'd0);
      vecs[1] = mk(0, 1, 0, 0, 64'hA2, 8'hF0, 1, 0, 64'hA1, 8'h0F, 5'd2, 0, 8'd0);
      vecs[2] = mk(0, 0, 0, 0, 64'h0,  8'h00, 1, 0, 64'hA1, 8'h0F, 5'd2, 0, 8'd0);
      vecs[3] = mk(0, 0, 0, 1, 64'h0,  8'h00, 1, 0, 64'hA2, 8'hF0, 5'd1, 0, 8'd0);
      vecs[4] = mk(0, 1, 1, 1, 64'hA3, 8'hFF, 0, 0, 64'h0,  8'h00, 5'd1, 0, 8'd0);
      vecs[5] = mk(0, 0, 0, 1, 64'h0,  8'h00, 1, 1, 64'hA3, 8'hFF, 5'd1, 0, 8'd0);
      vecs[6] = mk(1, 0, 0, 0, 64'h0,  8'h00, 1, 1, 64'hA3, 8'hFF, 5'd1, 0, 8'd0);
      vecs[7] = mk(0, 0, 0, 1, 64'h0,  8'h00, 0, 0, 64'h0,  8'h00, 5'd0, 0, 8'd0);
      for (int i = 0; i < 8; i++) begin
         frame_rst = vecs[i].frame_rst;
         in_valid  = vecs[i].in_valid;
         in_last   = vecs[i].in_last;
         in_data   = vecs[i].in_data;
         in_keep   = vecs[i].in_keep;
         m_tready  = vecs[i].m_tready;
         tick();
         check($sformatf("vec%0d valid", i), 73'(m_tvalid), 73'(vecs[i].exp_valid));
         check($sformatf("vec%0d fill", i), 73'(fill_level), 73'(vecs[i].exp_fill));
         check($sformatf("vec%0d overflow", i), 73'(overflow), 73'(vecs[i].exp_ov));
         check($sformatf("vec%0d drop_count", i), 73'(drop_count), 73'(vecs[i].exp_dc));
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d word", i), cur,
                  w(vecs[i].exp_last, vecs[i].exp_keep, vecs[i].exp_data));
         end
      end
      idle();
      m_tready = 1'b0;
      outq.delete();

      // Pass-through: 100-word frame at full rate
      m_tready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         push_word(i == 0, 64'h2000 + 64'(i), i == 99);
         expq.push_back(w(i == 99, 8'hFF, 64'h2000 + 64'(i)));
      end
      drain_and_compare("pass", 60);
      check("pass overflow", 73'(overflow), 73'(0));
      check("pass drop_count", 73'(drop_count), 73'(0));

      // Overflow mid-frame, last word arrives while still full -> terminator
      m_tready = 1'b0;
      for (int i = 0; i < 40; i++) push_word(i == 0, 64'h3000 + 64'(i), i == 39);
      check("ovf40 fill", 73'(fill_level), 73'(16));
      check("ovf40 overflow", 73'(overflow), 73'(1));
      check("ovf40 drop_count", 73'(drop_count), 73'(24));
      check("ovf40 state", 73'(dut.state_q), 73'(TERM));
      for (int i = 0; i < 16; i++) expq.push_back(w(1'b0, 8'hFF, 64'h3000 + 64'(i)));
      expq.push_back(w(1'b1, 8'hFF, 64'h0));
      drain_and_compare("ovf40", 60);

      // Overflow mid-frame, space frees before the last word -> last word written
      m_tready = 1'b0;
      for (int i = 0; i < 19; i++) push_word(i == 0, 64'h4000 + 64'(i), 1'b0);
      check("ovf20 drop_count mid", 73'(drop_count), 73'(3));
      m_tready = 1'b1;
      repeat (4) tick();
      push_word(1'b0, 64'h4013, 1'b1);
      check("ovf20 drop_count", 73'(drop_count), 73'(3));
      check("ovf20 overflow", 73'(overflow), 73'(1));
      for (int i = 0; i < 16; i++) expq.push_back(w(1'b0, 8'hFF, 64'h4000 + 64'(i)));
      expq.push_back(w(1'b1, 8'hFF, 64'h4013));
      drain_and_compare("ovf20", 60);

      // Last word arrives while full; then frame_rst coincides with a dropped word
      m_tready = 1'b0;
      for (int i = 0; i < 17; i++) push_word(i == 0, 64'h5000 + 64'(i), i == 16);
      check("lastfull drop_count", 73'(drop_count), 73'(1));
      check("lastfull state", 73'(dut.state_q), 73'(TERM));
      push_word(1'b1, 64'hDEAD, 1'b0);
      check("frst+drop drop_count", 73'(drop_count), 73'(1));
      check("frst+drop overflow", 73'(overflow), 73'(1));
      for (int i = 0; i < 16; i++) expq.push_back(w(1'b0, 8'hFF, 64'h5000 + 64'(i)));
      expq.push_back(w(1'b1, 8'hFF, 64'h0));
      drain_and_compare("lastfull", 60);

      // frame_rst during DROP: counters clear, terminator closes, new frame passes
      m_tready = 1'b0;
      for (int i = 0; i < 18; i++) push_word(i == 0, 64'h6000 + 64'(i), 1'b0);
      check("frstdrop drop_count pre", 73'(drop_count), 73'(2));
      frame_rst = 1'b1;
      tick();
      idle();
      check("frstdrop overflow", 73'(overflow), 73'(0));
      check("frstdrop drop_count", 73'(drop_count), 73'(0));
      check("frstdrop state", 73'(dut.state_q), 73'(TERM));
      m_tready = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 5; i++) push_word(i == 0, 64'h7000 + 64'(i), i == 4);
      for (int i = 0; i < 16; i++) expq.push_back(w(1'b0, 8'hFF, 64'h6000 + 64'(i)));
      expq.push_back(w(1'b1, 8'hFF, 64'h0));
      for (int i = 0; i < 5; i++) expq.push_back(w(i == 4, 8'hFF, 64'h7000 + 64'(i)));
      drain_and_compare("frstdrop", 60);
      check("newframe overflow", 73'(overflow), 73'(0));
      check("newframe drop_count", 73'(drop_count), 73'(0));

      // Random back-pressure at 30%, input throttled below DEPTH so nothing may be lost
      begin
         int sent = 0;
         int cyc = 0;
         while (sent < 40 && cyc < 2000) begin
            m_tready = ($urandom_range(0, 99) < 30);
            if (fill_level < 5'd14) begin
               frame_rst = (sent == 0);
               in_valid  = 1'b1;
               in_data   = 64'h8000 + 64'(sent);
               in_keep   = 8'hFF;
               in_last   = (sent == 39);
               expq.push_back(w(sent == 39, 8'hFF, 64'h8000 + 64'(sent)));
               sent++;
            end else begin
               idle();
            end
            tick();
            cyc++;
         end
         idle();
         check("random sent", 73'(sent), 73'(40));
      end
      drain_and_compare("random", 200);
      check("random drop_count", 73'(drop_count), 73'(0));
      check("random overflow", 73'(overflow), 73'(0));

      // Reset mid-stream with 10 entries stored
      m_tready = 1'b0;
      for (int i = 0; i < 10; i++) push_word(i == 0, 64'h9100 + 64'(i), 1'b0);
      check("midrst fill pre", 73'(fill_level), 73'(10));
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check("midrst m_tvalid", 73'(m_tvalid), 73'(0));
      check("midrst fill", 73'(fill_level), 73'(0));
      check("midrst state", 73'(dut.state_q), 73'(PASS));
      outq.delete();
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_word(i == 0, 64'h9000 + 64'(i), i == 2);
         expq.push_back(w(i == 2, 8'hFF, 64'h9000 + 64'(i)));
      end
      drain_and_compare("midrst", 30);

      // drop_count saturates at all-ones
      m_tready = 1'b0;
      for (int i = 0; i < 280; i++) push_word(i == 0, 64'hA000 + 64'(i), i == 279);
      check("sat drop_count", 73'(drop_count), 73'(255));
      check("sat overflow", 73'(overflow), 73'(1));
      check("sat fill", 73'(fill_level), 73'(16));
      for (int i = 0; i < 16; i++) expq.push_back(w(1'b0, 8'hFF, 64'hA000 + 64'(i)));
      expq.push_back(w(1'b1, 8'hFF, 64'h0));
      drain_and_compare("sat", 60);

      check("stall stability", 73'(stable_bad), 73'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
